// File: rtl/hpdmc_ddr_oe_gen.sv
// hpdmc_ddr_oe_gen: DDR write/read data-phase sequencer driving the PHY oe register pair.
// Produces {DQS oe, DQ oe}, its load enable, the read-capture window and command safety flags.
module hpdmc_ddr_oe_gen #(
   parameter int BURST_CYCLES = 4
) (
   input  logic       sys_clk,
   input  logic       sdram_rst,
   input  logic       tim_cas,
   input  logic [1:0] tim_wr,
   input  logic       write,
   input  logic       read,
   output logic [1:0] oe_d,
   output logic       oe_ce,
   output logic       rd_capture,
   output logic       write_safe,
   output logic       read_safe,
   output logic       proto_err
);
   typedef enum logic [2:0] {IDLE, WPRE, WDATA, WPOST, WREC, RWAIT, RDATA, RTURN} state_t;
   localparam logic [3:0] BLAST = 4'(BURST_CYCLES - 1);
   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] wr_q, wr_d;
   logic [1:0] oe_d_q, oe_d_d;
   logic       oe_ce_q, oe_ce_d;
   logic       rd_capture_q, rd_capture_d;
   logic       safe_q, safe_d;
   logic       proto_err_q, proto_err_d;
   wire        last = cnt_q == 4'd0;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - {3'b000, !last};
      wr_d    = wr_q;
      unique case (state_q)
         IDLE: begin
            if (write) begin
               state_d = WPRE;
               wr_d    = tim_wr;
            end else if (read) begin
               state_d = RWAIT;
               cnt_d   = tim_cas ? 4'd2 : 4'd1;
            end
         end
         WPRE: begin
            state_d = WDATA;
            cnt_d   = BLAST;
         end
         WDATA: state_d = last ? WPOST : WDATA;
         WPOST: begin
            state_d = WREC;
            cnt_d   = {2'b00, wr_q};
         end
         WREC: state_d = last ? IDLE : WREC;
         RWAIT: begin
            if (last) begin
               state_d = RDATA;
               cnt_d   = BLAST;
            end
         end
         RDATA: state_d = last ? RTURN : RDATA;
         RTURN: state_d = IDLE;
      endcase
      // outputs are registered from the next state so they line up with the state register
      oe_d_d       = state_d == WDATA ? 2'b11 : (state_d == WPRE || state_d == WPOST) ? 2'b10 : 2'b00;
      oe_ce_d      = oe_d_d != oe_d_q;
      rd_capture_d = state_d == RDATA;
      safe_d       = state_d == IDLE;
      proto_err_d  = proto_err_q | (write & read) | ((write | read) & (state_q != IDLE));
   end
   always_ff @(posedge sys_clk) begin
      if (sdram_rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         wr_q         <= 2'b00;
         oe_d_q       <= 2'b00;
         oe_ce_q      <= 1'b1;
         rd_capture_q <= 1'b0;
         safe_q       <= 1'b1;
         proto_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_q         <= wr_d;
         oe_d_q       <= oe_d_d;
         oe_ce_q      <= oe_ce_d;
         rd_capture_q <= rd_capture_d;
         safe_q       <= safe_d;
         proto_err_q  <= proto_err_d;
      end
   end
   assign oe_d       = oe_d_q;
   assign oe_ce      = oe_ce_q;
   assign rd_capture = rd_capture_q;
   assign write_safe = safe_q;
   assign read_safe  = safe_q;
   assign proto_err  = proto_err_q;
endmodule

// File: tb/tb_hpdmc_ddr_oe_gen.sv
// tb_hpdmc_ddr_oe_gen: directed stimulus with literal expectation tables plus a
// per-cycle comparison against an offset-based model of the command timelines.
module tb_hpdmc_ddr_oe_gen;
   localparam int B = 4;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tim_cas = 1'b0;
   logic [1:0] tim_wr = 2'b00;
   logic       write = 1'b0;
   logic       read = 1'b0;
   logic [1:0] oe_d;
   logic       oe_ce, rd_capture, write_safe, read_safe, proto_err;
   int         checks = 0;
   int         errors = 0;

   hpdmc_ddr_oe_gen #(.BURST_CYCLES(B)) dut (
      .sys_clk(clk), .sdram_rst(rst), .tim_cas(tim_cas), .tim_wr(tim_wr),
      .write(write), .read(read), .oe_d(oe_d), .oe_ce(oe_ce),
      .rd_capture(rd_capture), .write_safe(write_safe), .read_safe(read_safe),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: each command is a timeline measured from the cycle s holding its strobe.
   int         cyc = 0;
   int         mode = 0;
   int         s = 0, wrv = 0, clv = 0;
   bit         rstc = 0, err_m = 0, started = 0;
   logic [1:0] prev_oe = 2'b00;

   function automatic logic [1:0] m_oe(input int c);
      int k = c - s;
      if (mode != 1) return 2'b00;
      if (k == 1 || k == B + 2) return 2'b10;
      if (k >= 2 && k <= B + 1) return 2'b11;
      return 2'b00;
   endfunction

   function automatic bit m_busy(input int c);
      int k = c - s;
      if (mode == 1) return k >= 1 && k <= B + 3 + wrv;
      if (mode == 2) return k >= 1 && k <= clv + B + 1;
      return 1'b0;
   endfunction

   function automatic bit m_cap(input int c);
      int k = c - s;
      return mode == 2 && k >= clv + 1 && k <= clv + B;
   endfunction

   always @(posedge clk) begin
      bit idle;
      idle = rstc || !m_busy(cyc);
      if (rst) begin
         started = 1;
         rstc    = 1;
         mode    = 0;
         err_m   = 0;
      end else if (started) begin
         rstc = 0;
         if ((write || read) && (!idle || (write && read))) err_m = 1;
         if (idle && write) begin
            mode = 1; s = cyc; wrv = int'(tim_wr);
         end else if (idle && read) begin
            mode = 2; s = cyc; clv = tim_cas ? 3 : 2;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      logic [1:0] eo;
      if (started) begin
         eo = rstc ? 2'b00 : m_oe(cyc);
         chk("m_oe", {6'd0, oe_d}, {6'd0, eo});
         chk("m_ce", {7'd0, oe_ce}, {7'd0, rstc ? 1'b1 : (eo != prev_oe)});
         chk("m_cap", {7'd0, rd_capture}, {7'd0, !rstc && m_cap(cyc)});
         chk("m_wsafe", {7'd0, write_safe}, {7'd0, rstc || !m_busy(cyc)});
         chk("m_rsafe", {7'd0, read_safe}, {7'd0, rstc || !m_busy(cyc)});
         chk("m_err", {7'd0, proto_err}, {7'd0, err_m});
         prev_oe = eo;
      end
   end

   // Called at a negedge with the DUT idle; strobe sits in cycle T, records cycles T+1..T+n.
   task automatic run_seq(input string name, input bit w, input bit r, input bit cas,
                          input logic [1:0] wr, input int n, input int rd_at, input int rst_at,
                          input bit lit, input logic [31:0] oe_pat, input logic [15:0] ce_pat,
                          input logic [15:0] cap_pat, input logic [15:0] safe_pat);
      write = w; read = r; tim_cas = cas; tim_wr = wr;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         write = 0; read = 0; rst = 0; tim_cas = ~cas; tim_wr = ~wr;
         if (lit) begin
            chk({name, "_oe"}, {6'd0, oe_d}, {6'd0, oe_pat[2*k-2 +: 2]});
            chk({name, "_ce"}, {7'd0, oe_ce}, {7'd0, ce_pat[k-1]});
            chk({name, "_cap"}, {7'd0, rd_capture}, {7'd0, cap_pat[k-1]});
            chk({name, "_safe"}, {6'd0, write_safe, read_safe}, {6'd0, {2{safe_pat[k-1]}}});
         end
         if (k == rd_at) read = 1;
         if (k == rst_at) rst = 1;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ce", {7'd0, oe_ce}, 8'd1);
      chk("rst_oe", {6'd0, oe_d}, 8'd0);
      rst = 0;
      @(negedge clk);
      chk("rel_ce", {7'd0, oe_ce}, 8'd0);
      chk("rel_safe", {6'd0, write_safe, read_safe}, 8'd3);
      chk("rel_err", {7'd0, proto_err}, 8'd0);
      run_seq("wr", 1, 0, 0, 2'd2, 10, 0, 0, 1, 32'h00BFE, 16'b0001100011, 16'd0, 16'b1000000000);
      run_seq("rd2", 0, 1, 0, 2'd0, 8, 0, 0, 1, 32'd0, 16'd0, 16'b00111100, 16'b10000000);
      run_seq("rd3", 0, 1, 1, 2'd0, 9, 0, 0, 1, 32'd0, 16'd0, 16'b001111000, 16'b100000000);
      chk("err_clean", {7'd0, proto_err}, 8'd0);
      run_seq("both", 1, 1, 0, 2'd2, 10, 0, 0, 1, 32'h00BFE, 16'b0001100011, 16'd0, 16'b1000000000);
      chk("both_err", {7'd0, proto_err}, 8'd1);
      run_seq("sticky", 0, 1, 0, 2'd0, 8, 0, 0, 1, 32'd0, 16'd0, 16'b00111100, 16'b10000000);
      chk("sticky_err", {7'd0, proto_err}, 8'd1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("clr_err", {7'd0, proto_err}, 8'd0);
      run_seq("rdin", 1, 0, 0, 2'd2, 10, 3, 0, 1, 32'h00BFE, 16'b0001100011, 16'd0, 16'b1000000000);
      chk("rdin_err", {7'd0, proto_err}, 8'd1);
      run_seq("abort", 1, 0, 0, 2'd2, 8, 0, 4, 1, 32'h000FE, 16'b00010011, 16'd0, 16'b11110000);
      chk("abort_err", {7'd0, proto_err}, 8'd0);
      run_seq("wr0", 1, 0, 0, 2'd0, 8, 0, 0, 0, 32'd0, 16'd0, 16'd0, 16'd0);
      run_seq("rd3b", 0, 1, 1, 2'd0, 9, 0, 0, 0, 32'd0, 16'd0, 16'd0, 16'd0);
      run_seq("wr3", 1, 0, 0, 2'd3, 11, 0, 0, 0, 32'd0, 16'd0, 16'd0, 16'd0);
      run_seq("wr1", 1, 0, 1, 2'd1, 9, 0, 0, 0, 32'd0, 16'd0, 16'd0, 16'd0);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
